// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Lets NREQ byte sources take turns on one UART transmitter. A requester
//   offers a byte with valid/ready. The arbiter chooses one requester in
//   round-robin order and pulses the transmitter's start input with that
//   requester's byte. It then waits for the transmitter's frame-complete
//   tick and holds the line idle for GAP_TICKS baud ticks before it grants
//   again. A watchdog stops the wait if the transmitter never reports
//   completion, and it raises a sticky error when it does so.
//
// Ports:
//   clk          in   system clock
//   arst         in   asynchronous reset, active-high
//   en           in   block enable; low returns to IDLE and blocks grants
//   req_valid    in   [NREQ]   requester i has a byte ready
//   req_data     in   [8*NREQ] byte of requester i at [8*i+7:8*i]
//   req_ready    out  [NREQ]   one-hot, one-cycle accept pulse
//   s_tick       in   baud oversample tick shared with the transmitter
//   tx_busy      in   transmitter is busy
//   tx_done_tick in   transmitter frame-complete pulse
//   tx_start     out  one-cycle start pulse to the transmitter
//   tx_din       out  [8] byte for the transmitter, held until next grant
//   grant_id     out  index of the current or last granted requester
//   active       out  high whenever the scheduler is not IDLE
//   done_pulse   out  one-cycle pulse when a granted frame completes
//   timeout_err  out  sticky watchdog error
//   err_clr      in   clears timeout_err (a new timeout wins)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int GAP_TICKS = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      en,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [8*NREQ-1:0]         req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      s_tick,
    input  logic                      tx_busy,
    input  logic                      tx_done_tick,
    output logic                      tx_start,
    output logic [7:0]                tx_din,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      active,
    output logic                      done_pulse,
    output logic                      timeout_err,
    input  logic                      err_clr
);

    localparam int IDW = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);
    // A zero-tick gap still needs a legal one-bit counter, although it is never used.
    localparam int GCW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        GAP
    } state_t;

    state_t            state;
    logic [IDW-1:0]    last;
    logic [WDW-1:0]    wdog;
    logic [GCW-1:0]    gap_cnt;

    logic              any_valid;
    logic [IDW-1:0]    winner;
    logic [NREQ-1:0]   winner_onehot;
    logic [7:0]        winner_data;
    int                idx;

    // Round-robin search. It starts one place past the last winner and wraps
    // at NREQ, so a requester that was just served is checked last.
    always_comb begin
        any_valid     = 1'b0;
        winner        = last;
        winner_onehot = '0;
        idx           = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(last) + off) % NREQ;
            if (!any_valid && req_valid[idx]) begin
                any_valid          = 1'b1;
                winner             = IDW'(idx);
                winner_onehot[idx] = 1'b1;
            end
        end
    end

    assign winner_data = req_data[{winner, 3'b000} +: 8];

    // Main scheduler. Every output is registered. The pulse outputs return
    // to zero each cycle unless a state asserts them. en=0 leaves the last
    // grant, the RR pointer and the error flag as they are, so the rotation
    // continues when the block is enabled again.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= IDLE;
            last        <= IDW'(NREQ - 1);
            wdog        <= '0;
            gap_cnt     <= '0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_din      <= 8'h00;
            grant_id    <= '0;
            active      <= 1'b0;
            done_pulse  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            req_ready  <= '0;
            done_pulse <= 1'b0;

            // A timeout in the same cycle is assigned later and overrides this clear.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            if (!en) begin
                state   <= IDLE;
                active  <= 1'b0;
                wdog    <= '0;
                gap_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!tx_busy && any_valid) begin
                            tx_din    <= winner_data;
                            grant_id  <= winner;
                            last      <= winner;
                            req_ready <= winner_onehot;
                            tx_start  <= 1'b1;
                            active    <= 1'b1;
                            state     <= LAUNCH;
                        end
                    end

                    LAUNCH: begin
                        wdog  <= '0;
                        state <= WAIT_DONE;
                    end

                    // When completion and timeout arrive together, completion wins.
                    WAIT_DONE: begin
                        if (tx_done_tick || (wdog == WDW'(TIMEOUT - 1))) begin
                            if (tx_done_tick) begin
                                done_pulse <= 1'b1;
                            end else begin
                                timeout_err <= 1'b1;
                            end
                            wdog <= '0;
                            if (GAP_TICKS == 0) begin
                                state  <= IDLE;
                                active <= 1'b0;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end

                    // The counter stops at GAP_TICKS, so it cannot wrap.
                    GAP: begin
                        if (gap_cnt == GCW'(GAP_TICKS)) begin
                            gap_cnt <= '0;
                            state   <= IDLE;
                            active  <= 1'b0;
                        end else if (s_tick) begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. It uses four requesters, a 16-tick
// gap and a 64-cycle watchdog. A second instance with no gap sees the same
// inputs during the first frame. The bench acts as the transmitter: it
// drives tx_busy and tx_done_tick itself and produces s_tick once every
// four clocks.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic        clk;
    logic        arst;
    logic        en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        s_tick;
    logic        tx_busy;
    logic        tx_done_tick;
    logic        err_clr;

    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic [1:0]  grant_id;
    logic        active;
    logic        done_pulse;
    logic        timeout_err;

    logic [3:0]  u1_req_ready;
    logic        u1_tx_start;
    logic [7:0]  u1_tx_din;
    logic [1:0]  u1_grant_id;
    logic        u1_active;
    logic        u1_done_pulse;
    logic        u1_timeout_err;

    int compared   = 0;
    int mismatched = 0;

    uart_tx_arbiter #(.NREQ(4), .GAP_TICKS(16), .TIMEOUT(64)) u0 (
        .clk          (clk),
        .arst         (arst),
        .en           (en),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .s_tick       (s_tick),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .grant_id     (grant_id),
        .active       (active),
        .done_pulse   (done_pulse),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr)
    );

    uart_tx_arbiter #(.NREQ(4), .GAP_TICKS(0), .TIMEOUT(64)) u1 (
        .clk          (clk),
        .arst         (arst),
        .en           (en),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (u1_req_ready),
        .s_tick       (s_tick),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .tx_start     (u1_tx_start),
        .tx_din       (u1_tx_din),
        .grant_id     (u1_grant_id),
        .active       (u1_active),
        .done_pulse   (u1_done_pulse),
        .timeout_err  (u1_timeout_err),
        .err_clr      (err_clr)
    );

    // 100 MHz-style clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick: one cycle high in every four. It changes on the falling
    // edge so that it is stable at each rising edge.
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
        req_valid = valid;
        req_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Waits, with a cycle limit, for a start pulse. It also counts the baud
    // ticks it sees while waiting.
    task automatic waitGrant(input string tag, output int ticks_seen);
        int n;
        n          = 0;
        ticks_seen = 0;
        while (tx_start !== 1'b1 && n < 300) begin
            if (s_tick === 1'b1) ticks_seen++;
            tick();
            n++;
        end
        checkOutput({tag, "_start"}, 32'(tx_start), 32'd1);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (active !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(active), 32'd0);
    endtask

    task automatic checkGrant(input string tag, input int id, input logic [7:0] din);
        checkOutput({tag, "_grant_id"}, 32'(grant_id), 32'(id));
        checkOutput({tag, "_tx_din"}, 32'(tx_din), 32'(din));
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'(4'b0001 << id));
        checkOutput({tag, "_active"}, 32'(active), 32'd1);
    endtask

    // Runs from the LAUNCH cycle. It plays a frame of len busy cycles and
    // then a completion tick.
    task automatic finishFrame(input string tag, input int len);
        tx_busy = 1'b1;
        tick();
        checkOutput({tag, "_ready_drop"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_start_drop"}, 32'(tx_start), 32'd0);
        repeat (len) tick();
        tx_done_tick = 1'b1;
        tick();
        checkOutput({tag, "_done_pulse"}, 32'(done_pulse), 32'd1);
        tx_done_tick = 1'b0;
        tx_busy      = 1'b0;
        tick();
        checkOutput({tag, "_done_drop"}, 32'(done_pulse), 32'd0);
    endtask

    initial begin
        int sticks;
        int starts;
        logic saw_done;

        arst         = 1'b1;
        en           = 1'b1;
        err_clr      = 1'b0;
        tx_busy      = 1'b0;
        tx_done_tick = 1'b0;
        applyStimulus(4'b0000, 32'h0);
        tick();
        tick();

        // Reset state
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
        checkOutput("rst_tx_din", 32'(tx_din), 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
        checkOutput("rst_active", 32'(active), 32'd0);
        checkOutput("rst_done_pulse", 32'(done_pulse), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        arst = 1'b0;

        // Test 1: requester 2 alone, then the gap before it is granted again
        $display("[TB] test 1: single requester and inter-frame gap");
        applyStimulus(4'b0100, 32'h00A5_0000);
        tick();
        checkGrant("t1_g0", 2, 8'hA5);
        checkOutput("t1_g0_tx_start", 32'(tx_start), 32'd1);
        applyStimulus(4'b0000, 32'h00A5_0000);
        tx_busy = 1'b1;
        tick();
        checkOutput("t1_ready_drop", 32'(req_ready), 32'd0);
        checkOutput("t1_start_drop", 32'(tx_start), 32'd0);
        repeat (4) tick();
        tx_done_tick = 1'b1;
        tick();
        checkOutput("t1_done_pulse", 32'(done_pulse), 32'd1);
        checkOutput("t1_in_gap", 32'(active), 32'd1);
        checkOutput("t1_nogap_done", 32'(u1_done_pulse), 32'd1);
        checkOutput("t1_nogap_idle", 32'(u1_active), 32'd0);
        checkOutput("t1_nogap_grant", 32'(u1_grant_id), 32'd2);
        checkOutput("t1_nogap_din", 32'(u1_tx_din), 32'hA5);
        checkOutput("t1_nogap_ready", 32'(u1_req_ready), 32'd0);
        checkOutput("t1_nogap_start", 32'(u1_tx_start), 32'd0);
        checkOutput("t1_nogap_err", 32'(u1_timeout_err), 32'd0);
        tx_done_tick = 1'b0;
        tx_busy      = 1'b0;
        applyStimulus(4'b0100, 32'h00A5_0000);
        waitGrant("t1_g1", sticks);
        checkOutput("t1_gap_ticks", 32'(sticks), 32'd16);
        checkGrant("t1_g1", 2, 8'hA5);
        checkOutput("t1_g1_no_done", 32'(done_pulse), 32'd0);
        applyStimulus(4'b0000, 32'h00A5_0000);
        finishFrame("t1_f1", 4);

        // Test 2: all requesters valid after a fresh reset
        $display("[TB] test 2: full rotation");
        arst = 1'b1;
        tick();
        arst = 1'b0;
        applyStimulus(4'b1111, 32'h1312_1110);
        for (int i = 0; i < 5; i++) begin
            waitGrant($sformatf("t2_g%0d", i), sticks);
            checkGrant($sformatf("t2_g%0d", i), i % 4, 8'(8'h10 + (i % 4)));
            finishFrame($sformatf("t2_f%0d", i), 5);
        end

        // Test 3: requesters 0 and 3 alternate; a busy transmitter blocks grants
        $display("[TB] test 3: two requesters and busy hold-off");
        applyStimulus(4'b1001, 32'h3300_0030);
        for (int i = 0; i < 4; i++) begin
            waitGrant($sformatf("t3_g%0d", i), sticks);
            checkGrant($sformatf("t3_g%0d", i), (i % 2 == 0) ? 3 : 0,
                       (i % 2 == 0) ? 8'h33 : 8'h30);
            finishFrame($sformatf("t3_f%0d", i), 3);
        end
        tx_busy = 1'b1;
        starts  = 0;
        repeat (100) begin
            tick();
            if (tx_start === 1'b1) starts++;
        end
        checkOutput("t3_busy_no_start", 32'(starts), 32'd0);
        checkOutput("t3_busy_idle", 32'(active), 32'd0);
        tx_busy = 1'b0;
        tick();
        checkGrant("t3_after_busy", 3, 8'h33);
        applyStimulus(4'b0010, 32'h0000_4100);
        finishFrame("t3_f4", 3);

        // Test 4: watchdog timeout, err_clr, and a set winning over a clear
        $display("[TB] test 4: watchdog");
        waitGrant("t4_g0", sticks);
        checkGrant("t4_g0", 1, 8'h41);
        tx_busy  = 1'b1;
        saw_done = 1'b0;
        repeat (64) begin
            tick();
            if (done_pulse === 1'b1) saw_done = 1'b1;
        end
        checkOutput("t4_err_before", 32'(timeout_err), 32'd0);
        tick();
        checkOutput("t4_err_rise", 32'(timeout_err), 32'd1);
        checkOutput("t4_no_done", 32'(done_pulse), 32'd0);
        checkOutput("t4_no_done_window", 32'(saw_done), 32'd0);
        checkOutput("t4_to_gap", 32'(active), 32'd1);
        applyStimulus(4'b0000, 32'h0000_4100);
        tx_busy = 1'b0;
        waitIdle("t4_a");
        checkOutput("t4_err_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("t4_err_cleared", 32'(timeout_err), 32'd0);
        applyStimulus(4'b0010, 32'h0000_4100);
        waitGrant("t4_g1", sticks);
        checkGrant("t4_g1", 1, 8'h41);
        applyStimulus(4'b0000, 32'h0000_4100);
        tx_busy = 1'b1;
        repeat (64) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("t4_set_wins", 32'(timeout_err), 32'd1);
        tick();
        checkOutput("t4_set_holds", 32'(timeout_err), 32'd1);
        tx_busy = 1'b0;
        waitIdle("t4_b");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("t4_err_cleared2", 32'(timeout_err), 32'd0);

        // Test 5: disable during WAIT_DONE, then re-enable
        $display("[TB] test 5: enable drop mid-frame");
        applyStimulus(4'b1111, 32'h5352_5150);
        waitGrant("t5_g0", sticks);
        checkGrant("t5_g0", 2, 8'h52);
        tx_busy = 1'b1;
        tick();
        tick();
        checkOutput("t5_waiting", 32'(active), 32'd1);
        en           = 1'b0;
        tx_done_tick = 1'b1;
        tick();
        checkOutput("t5_idle", 32'(active), 32'd0);
        checkOutput("t5_no_done", 32'(done_pulse), 32'd0);
        checkOutput("t5_keep_grant", 32'(grant_id), 32'd2);
        checkOutput("t5_keep_din", 32'(tx_din), 32'h52);
        tx_done_tick = 1'b0;
        tx_busy      = 1'b0;
        tick();
        tick();
        checkOutput("t5_disabled_start", 32'(tx_start), 32'd0);
        checkOutput("t5_disabled_ready", 32'(req_ready), 32'd0);
        en = 1'b1;
        waitGrant("t5_g1", sticks);
        checkGrant("t5_g1", 3, 8'h53);
        finishFrame("t5_f1", 4);

        // Test 6: asynchronous reset during the gap
        $display("[TB] test 6: async reset mid-gap");
        repeat (3) tick();
        checkOutput("t6_in_gap", 32'(active), 32'd1);
        #2;
        arst = 1'b1;
        #1;
        checkOutput("t6_rst_active", 32'(active), 32'd0);
        checkOutput("t6_rst_grant_id", 32'(grant_id), 32'd0);
        checkOutput("t6_rst_tx_din", 32'(tx_din), 32'd0);
        checkOutput("t6_rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("t6_rst_tx_start", 32'(tx_start), 32'd0);
        arst = 1'b0;
        waitGrant("t6_g0", sticks);
        checkGrant("t6_g0", 0, 8'h50);
        finishFrame("t6_f0", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
